// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-access stage: opcode and FSM state
// encodings and the default data-memory window.
package mem_stage_pkg;

   localparam int unsigned DMEM_BASE_DEFAULT  = 512;
   localparam int unsigned DMEM_LIMIT_DEFAULT = 1023;

   typedef enum logic [1:0] {
      OP_PASS  = 2'b00,
      OP_LOAD  = 2'b01,
      OP_STORE = 2'b10,
      OP_RSVD  = 2'b11
   } ex_op_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

   // Reserved opcode falls through to pass-through handling.
   function automatic logic is_mem_op(input ex_op_e op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/mem_range_check.sv
// Combinational legality check for a data-memory byte address: inside the
// [DMEM_BASE, DMEM_LIMIT] window and 8-byte aligned.
module mem_range_check
   import mem_stage_pkg::*;
#(
   parameter int unsigned DMEM_BASE  = DMEM_BASE_DEFAULT,
   parameter int unsigned DMEM_LIMIT = DMEM_LIMIT_DEFAULT
) (
   input  logic [63:0] addr,
   output logic        ok
);

   localparam logic [63:0] BASE  = 64'(DMEM_BASE);
   localparam logic [63:0] LIMIT = 64'(DMEM_LIMIT);

   logic in_window;
   logic aligned;

   always_comb begin
      in_window = (addr >= BASE) && (addr <= LIMIT);
      aligned   = (addr[2:0] == 3'b000);
      ok        = in_window && aligned;
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: accepts one execute-stage request at a time, performs
// the load/store against the segmented memory and returns a writeback record.
module mem_access_unit
   import mem_stage_pkg::*;
#(
   parameter int unsigned DMEM_BASE  = DMEM_BASE_DEFAULT,
   parameter int unsigned DMEM_LIMIT = DMEM_LIMIT_DEFAULT,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [1:0]  ex_op,
   input  logic [63:0] ex_addr,
   input  logic [63:0] ex_wdata,
   input  logic [63:0] ex_alu_result,
   input  logic [4:0]  ex_rd,
   output logic [63:0] mem_address,
   output logic [63:0] mem_data_in,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [63:0] mem_data_out,
   input  logic        mem_valid,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [63:0] wb_data,
   output logic        wb_we,
   output logic        wb_fault
);

   localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

   state_e      state_q, state_d;
   ex_op_e      op_q, op_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [63:0] wb_data_q, wb_data_d;
   logic        wb_we_q, wb_we_d;
   logic        wb_fault_q, wb_fault_d;
   logic        addr_ok;

   mem_range_check #(
      .DMEM_BASE  (DMEM_BASE),
      .DMEM_LIMIT (DMEM_LIMIT)
   ) u_range_check (
      .addr (ex_addr),
      .ok   (addr_ok)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= OP_PASS;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_we_q    <= 1'b0;
         wb_fault_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_we_q    <= wb_we_d;
         wb_fault_q <= wb_fault_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      wb_we_d    = wb_we_q;
      wb_fault_d = wb_fault_q;
      ex_ready   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      wb_valid   = 1'b0;

      unique case (state_q)
         IDLE: begin
            ex_ready = 1'b1;
            if (ex_valid) begin
               op_d    = ex_op_e'(ex_op);
               addr_d  = ex_addr;
               wdata_d = ex_wdata;
               wb_rd_d = ex_rd;
               cnt_d   = '0;
               if (!is_mem_op(op_d)) begin
                  state_d    = RESP;
                  wb_data_d  = ex_alu_result;
                  wb_we_d    = 1'b1;
                  wb_fault_d = 1'b0;
               end else if (!addr_ok) begin
                  state_d    = RESP;
                  wb_data_d  = '0;
                  wb_we_d    = 1'b0;
                  wb_fault_d = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
            end
         end

         ISSUE, WAIT: begin
            mem_read  = (state_q == ISSUE) && (op_q == OP_LOAD);
            mem_write = (state_q == ISSUE) && (op_q == OP_STORE);
            if (mem_valid) begin
               state_d    = RESP;
               wb_fault_d = 1'b0;
               if (op_q == OP_LOAD) begin
                  wb_data_d = mem_data_out;
                  wb_we_d   = 1'b1;
               end else begin
                  wb_data_d = '0;
                  wb_we_d   = 1'b0;
               end
            end else if (state_q == ISSUE) begin
               state_d = WAIT;
            end else if (cnt_q + 4'd1 == TIMEOUT_CNT) begin
               // Count reaches TIMEOUT on the last WAIT cycle; a completion
               // arriving on that same cycle still wins over the fault.
               state_d    = RESP;
               cnt_d      = cnt_q + 4'd1;
               wb_data_d  = '0;
               wb_we_d    = 1'b0;
               wb_fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         RESP: begin
            wb_valid = 1'b1;
            if (wb_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign mem_address = addr_q;
   assign mem_data_in = wdata_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign wb_we       = wb_we_q;
   assign wb_fault    = wb_fault_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DMEM_BASE, default 512, the lowest legal data-memory byte address.
REQ-002 SHALL have parameter DMEM_LIMIT, default 1023, the highest legal data-memory byte address.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of WAIT cycles before a fault.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port ex_valid, input, 1 bit: the execute stage presents a request.
REQ-007 SHALL have port ex_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-008 SHALL have port ex_op, input, 2 bits: 00 pass-through, 01 load, 10 store, 11 reserved (treated as pass-through).
REQ-009 SHALL have port ex_addr, input, 64 bits: byte address.
REQ-010 SHALL have port ex_wdata, input, 64 bits: store data.
REQ-011 SHALL have port ex_alu_result, input, 64 bits: pass-through result.
REQ-012 SHALL have port ex_rd, input, 5 bits: destination register.
REQ-013 SHALL have port mem_address, output, 64 bits: address to the segmented memory.
REQ-014 SHALL have port mem_data_in, output, 64 bits: data to the segmented memory.
REQ-015 SHALL have ports mem_read and mem_write, outputs, 1 bit each: memory strobes.
REQ-016 SHALL have port mem_data_out, input, 64 bits: data from the segmented memory.
REQ-017 SHALL have port mem_valid, input, 1 bit: the memory completes the access.
REQ-018 SHALL have ports wb_valid, output, and wb_ready, input, 1 bit each: the writeback handshake.
REQ-019 SHALL have ports wb_rd (5), wb_data (64), wb_we (1) and wb_fault (1), all outputs: the writeback payload.

Function
REQ-020 SHALL implement a state machine with states IDLE, ISSUE, WAIT and RESP; ex_ready SHALL be 1 only in IDLE.
REQ-021 On accept (ex_valid and ex_ready), the unit SHALL register op, addr, wdata, alu_result and rd.
- A pass-through op SHALL go to RESP with wb_data = alu_result and wb_we = 1.
REQ-022 A load or store SHALL be checked on accept:
- The address SHALL be in [DMEM_BASE, DMEM_LIMIT] and have addr[2:0] = 0.
- A failing address SHALL go to RESP with wb_fault = 1, wb_we = 0 and no memory strobe.
REQ-023 ISSUE SHALL last exactly one cycle and drive:
- mem_read = 1 for a load, or mem_write = 1 for a store;
- mem_address and mem_data_in from the registered values.
- Strobes SHALL be 0 in every other state.
REQ-024 mem_valid SHALL be honoured in ISSUE or WAIT:
- A load SHALL capture mem_data_out into wb_data with wb_we = 1.
- A store SHALL set wb_we = 0 and wb_data = 0.
- The next state SHALL be RESP.
REQ-025 In WAIT, a 4-bit counter SHALL increment each cycle.
- When it reaches TIMEOUT without mem_valid: go to RESP with wb_fault = 1, wb_we = 0.
- The counter SHALL clear on entry to ISSUE.
REQ-026 In RESP, wb_valid SHALL be 1 and all wb_* outputs stable until wb_ready; then go to IDLE.
REQ-027 mem_valid outside ISSUE or WAIT SHALL be ignored.
REQ-028 Minimum latency SHALL be as follows:
- load/store with mem_valid in ISSUE: accept edge to wb_valid = 2 cycles;
- pass-through: 1 cycle.
REQ-029 The unit SHALL hold no more than one outstanding request; there is no back-to-back overlap.

Reset
REQ-030 rst SHALL immediately force:
- state IDLE and counter 0;
- mem_read, mem_write, wb_valid, wb_we and wb_fault to 0;
- mem_address, mem_data_in, wb_data and wb_rd to 0.
REQ-031 A reset mid-ISSUE or mid-WAIT SHALL drop the request silently; no response SHALL be produced after reset.

Structure
REQ-032 Package mem_stage_pkg SHALL hold the ex_op enum, the state enum, and the DMEM_BASE/DMEM_LIMIT defaults.
REQ-033 The range/alignment check SHALL be a combinational sub-module, mem_range_check.

Verification
REQ-034 Load from addr 512, mem_valid in ISSUE with data 64'h123456789ABCDEF0 -> wb_valid 2 cycles after accept, wb_data = that value, wb_we = 1, wb_fault = 0.
REQ-035 Store to addr 520 with data 64'hDEADBEEF -> mem_write pulses for exactly 1 cycle with mem_address = 520 and mem_data_in = 64'hDEADBEEF; response has wb_we = 0.
REQ-036 Load from addr 10 and from addr 513 -> no strobe, wb_fault = 1 after 1 cycle.
REQ-037 Load to addr 600 with mem_valid never asserted -> wb_fault = 1 after TIMEOUT WAIT cycles, ex_ready = 0 throughout.
REQ-038 wb_ready held 0 for 5 cycles in RESP -> wb_* outputs stable and ex_ready = 0; IDLE the cycle after wb_ready = 1.
REQ-039 rst asserted during WAIT, then a late mem_valid -> outputs 0, state IDLE, no wb_valid.
